mem_test_checker: RTL

Read-back checker for the memory-test device: after a pattern writer has filled a region with a walking-ones pattern, this block sweeps the same address range and issues one read per address. It compares each returned word against the regenerated expected pattern and reports the mismatch count, the first failing address and data, and completion. It sits between the memTest controller and the memory read port, as the read/verify counterpart of the pattern write path.

---
 rtl/mem_test_pkg.sv | 39 +++
 rtl/mem_test_checker_adder.sv | 17 +
 rtl/mem_test_checker.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mem_test_pkg.sv
// mem_test_pkg: shared types and helpers for the memory-test read-back path.
//   state_e     : checker FSM state encoding (IDLE, REQ, WAIT, DONE)
//   c_*_WIDTH   : default address / data / error-counter widths
//   rotl1()     : rotate-left-by-one of the low w bits of a word, used to
//                 regenerate the walking-ones expected pattern
package mem_test_pkg;

  localparam int unsigned c_ADDR_WIDTH = 8;
  localparam int unsigned c_DATA_WIDTH = 8;
  localparam int unsigned c_CNT_WIDTH  = 16;

  // Widest data word rotl1() can handle.
  localparam int unsigned c_ROT_MAX_W = 64;
  localparam logic [c_ROT_MAX_W-1:0] c_ROT_ONE = c_ROT_MAX_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_e;

  // Rotate the low w bits of v left by one; bits at and above w must be zero
  // on entry and are zero on return. Shift-and-mask form keeps the width
  // generic without variable bit-selects.
  function automatic logic [c_ROT_MAX_W-1:0] rotl1(
    input logic [c_ROT_MAX_W-1:0] v,
    input int unsigned            w
  );
    logic [c_ROT_MAX_W-1:0] mask;
    if (w >= c_ROT_MAX_W) begin
      mask = '1;
    end else begin
      mask = (c_ROT_ONE << w) - c_ROT_ONE;
    end
    return ((v << 1) | (v >> (w - 1))) & mask;
  endfunction

endpackage

// File: rtl/mem_test_checker_adder.sv
// mem_test_checker_adder: plain unsigned adder with carry-out.
//   p_WIDTH     : operand width
//   i_DIN0/1    : operands
//   o_DOUT      : sum, modulo 2**p_WIDTH
//   o_OVERFLOW  : carry out of the top bit
module mem_test_checker_adder #(
  parameter int unsigned p_WIDTH = 8
) (
  input  logic [p_WIDTH-1:0] i_DIN0,
  input  logic [p_WIDTH-1:0] i_DIN1,
  output logic [p_WIDTH-1:0] o_DOUT,
  output logic               o_OVERFLOW
);

  assign {o_OVERFLOW, o_DOUT} = {1'b0, i_DIN0} + {1'b0, i_DIN1};

endmodule

// File: rtl/mem_test_checker.sv
// mem_test_checker: read-back checker for a walking-ones memory test.
// Sweeps base..last (inclusive, wrapping through zero when last < base),
// issuing one read per address and comparing each returned word against a
// regenerated expected pattern that starts at the seed and rotates left by
// one per address.
//
// Ports:
//   i_CLK, i_RST                     clock, synchronous active-high reset
//   i_START                          start pulse, honoured only in IDLE
//   i_BASE_ADDR, i_LAST_ADDR, i_SEED sweep setup, captured on start
//   o_RD_EN, o_RD_ADDR               one-cycle read request
//   i_RD_DATA, i_RD_VALID            read response, accepted only in WAIT
//   o_BUSY, o_DONE                   sweep in progress / one-cycle end pulse
//   o_ERROR, o_ERR_COUNT             sticky mismatch flag, saturating count
//   o_ERR_ADDR, o_ERR_DATA           address and data of the first mismatch
//
// Build option: define MEMTEST_STOP_ON_ERROR_EN to end the sweep at the
// first mismatch instead of sweeping the whole range.
module mem_test_checker
  import mem_test_pkg::*;
#(
  parameter int unsigned p_ADDR_WIDTH = c_ADDR_WIDTH,
  parameter int unsigned p_DATA_WIDTH = c_DATA_WIDTH,
  parameter int unsigned p_CNT_WIDTH  = c_CNT_WIDTH
) (
  input  logic                    i_CLK,
  input  logic                    i_RST,
  input  logic                    i_START,
  input  logic [p_ADDR_WIDTH-1:0] i_BASE_ADDR,
  input  logic [p_ADDR_WIDTH-1:0] i_LAST_ADDR,
  input  logic [p_DATA_WIDTH-1:0] i_SEED,
  output logic                    o_RD_EN,
  output logic [p_ADDR_WIDTH-1:0] o_RD_ADDR,
  input  logic [p_DATA_WIDTH-1:0] i_RD_DATA,
  input  logic                    i_RD_VALID,
  output logic                    o_BUSY,
  output logic                    o_DONE,
  output logic                    o_ERROR,
  output logic [p_CNT_WIDTH-1:0]  o_ERR_COUNT,
  output logic [p_ADDR_WIDTH-1:0] o_ERR_ADDR,
  output logic [p_DATA_WIDTH-1:0] o_ERR_DATA
);

`ifdef MEMTEST_STOP_ON_ERROR_EN
  localparam bit c_STOP_ON_ERROR = 1'b1;
`else
  localparam bit c_STOP_ON_ERROR = 1'b0;
`endif

  state_e                  state_q;
  logic [p_ADDR_WIDTH-1:0] addr_q;
  logic [p_ADDR_WIDTH-1:0] addr_d;
  logic [p_ADDR_WIDTH-1:0] last_q;
  logic [p_DATA_WIDTH-1:0] exp_q;
  logic                    rd_en_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    error_q;
  logic [p_CNT_WIDTH-1:0]  err_cnt_q;
  logic [p_ADDR_WIDTH-1:0] err_addr_q;
  logic [p_DATA_WIDTH-1:0] err_data_q;
  logic                    rd_mismatch;
  logic                    addr_carry_unused;

  // Carry-out is deliberately dropped so the sweep wraps through zero.
  mem_test_checker_adder #(
    .p_WIDTH (p_ADDR_WIDTH)
  ) u_addr_inc (
    .i_DIN0     (addr_q),
    .i_DIN1     (p_ADDR_WIDTH'(1)),
    .o_DOUT     (addr_d),
    .o_OVERFLOW (addr_carry_unused)
  );

  always_comb begin
    rd_mismatch = (i_RD_DATA != exp_q);
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      last_q     <= '0;
      exp_q      <= '0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      err_data_q <= '0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_START) begin
            last_q     <= i_LAST_ADDR;
            addr_q     <= i_BASE_ADDR;
            exp_q      <= i_SEED;
            error_q    <= 1'b0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
            err_data_q <= '0;
            busy_q     <= 1'b1;
            rd_en_q    <= 1'b1;
            state_q    <= ST_REQ;
          end
        end
        ST_REQ: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_RD_VALID) begin
            if (rd_mismatch) begin
              if (err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + p_CNT_WIDTH'(1);
              end
              if (!error_q) begin
                err_addr_q <= addr_q;
                err_data_q <= i_RD_DATA;
              end
              error_q <= 1'b1;
            end
            if ((c_STOP_ON_ERROR && rd_mismatch) || (addr_q == last_q)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              addr_q  <= addr_d;
              exp_q   <= p_DATA_WIDTH'(rotl1(c_ROT_MAX_W'(exp_q), p_DATA_WIDTH));
              rd_en_q <= 1'b1;
              state_q <= ST_REQ;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_RD_EN     = rd_en_q;
  assign o_RD_ADDR   = addr_q;
  assign o_BUSY      = busy_q;
  assign o_DONE      = done_q;
  assign o_ERROR     = error_q;
  assign o_ERR_COUNT = err_cnt_q;
  assign o_ERR_ADDR  = err_addr_q;
  assign o_ERR_DATA  = err_data_q;

endmodule
